// File: rtl/game_pkg.sv
// Shared definitions between the game controller, the bird physics block and
// the pipe scroller: controller state encodings and screen geometry.
package game_pkg;

  localparam logic [2:0] ST_BEGIN = 3'b100;
  localparam logic [2:0] ST_DOWN  = 3'b001;
  localparam logic [2:0] ST_UP    = 3'b010;
  localparam logic [2:0] ST_DEAD  = 3'b011;

  localparam int SCREEN_H = 480;
  localparam int BIRD_H   = 24;

  // Lowest legal top-edge y: the bird sprite rests on the bottom of the screen.
  localparam int Y_GROUND = SCREEN_H - BIRD_H;

  // Controller states in which the bird is under player control.
  function automatic logic is_flying_state(input logic [2:0] st);
    return (st == ST_DOWN) || (st == ST_UP);
  endfunction

endpackage

// File: rtl/bird_motion_frame_divider.sv
// Free-running frame divider: counts 0..FRAME_DIV-1 and raises tick for the
// single cycle the count sits at its terminal value. Shared with the pipe
// scroller so both blocks step on the same frame boundary.
module frame_divider #(
  parameter int FRAME_DIV = 833333
) (
  input  logic CLK,
  input  logic SW,
  output logic tick
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == CNT_LAST);
  assign tick    = at_last;

  // Next count: wrap to zero after the terminal value.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (at_last) begin
      cnt_d = '0;
    end
  end

  // Counter register; reset restarts the frame from zero.
  always_ff @(posedge CLK or negedge SW) begin
    if (!SW) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bird_motion.sv
// Per-frame vertical physics for the bird: gravity, flap impulse, ground,
// ceiling and pipe collision, and the post-death fall to the ground.
//
// phase    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bird parked at Y_START waiting for the controller to start
// FLY      | player control: flaps and gravity, collisions checked
// FALLING  | dead after pipe/ceiling hit, gravity only until ground
// GROUNDED | dead bird resting on the ground, everything held
module bird_motion
  import game_pkg::*;
#(
  parameter int Y_START   = 228,
  parameter int GRAVITY   = 1,
  parameter int FLAP_VEL  = 8,
  parameter int VMAX      = 10,
  parameter int FRAME_DIV = 833333
) (
  input  logic       CLK,
  input  logic       SW,
  input  logic [2:0] state,
  input  logic       hit_pipe,
  output logic       frame_tick,
  output logic [9:0] bird_y,
  output logic       dead,
  output logic       grounded
);

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_FLY,
    PH_FALLING,
    PH_GROUNDED
  } phase_t;

  localparam logic [9:0]         Y_START10 = 10'(Y_START);
  localparam logic [9:0]         Y_GND10   = 10'(Y_GROUND);
  localparam logic signed [10:0] Y_GND11   = 11'(Y_GROUND);
  localparam logic signed [6:0]  VMAX7     = 7'(VMAX);
  localparam logic signed [5:0]  VFLAP     = 6'(-FLAP_VEL);

  phase_t             phase_q, phase_d;
  logic [9:0]         bird_y_q, bird_y_d;
  logic signed [5:0]  vel_q, vel_d;
  logic               dead_q, dead_d;
  logic               grounded_q, grounded_d;

  logic               tick;
  logic signed [6:0]  vel_inc;
  logic signed [5:0]  vel_grav;
  logic signed [5:0]  vel_step;
  logic signed [10:0] ny;
  logic               do_fly;

  frame_divider #(
    .FRAME_DIV(FRAME_DIV)
  ) u_frame_divider (
    .CLK (CLK),
    .SW  (SW),
    .tick(tick)
  );

  // Candidate velocity and next position for this frame. Flaps only count
  // while the player is in control; a falling bird just feels gravity.
  always_comb begin
    vel_inc  = $signed({vel_q[5], vel_q}) + $signed(7'(GRAVITY));
    vel_grav = (vel_inc > VMAX7) ? VMAX7[5:0] : vel_inc[5:0];
    do_fly   = (phase_q == PH_FLY) ||
               ((phase_q == PH_IDLE) && is_flying_state(state));
    vel_step = (do_fly && (state == ST_UP)) ? VFLAP : vel_grav;
    ny       = $signed({1'b0, bird_y_q}) + $signed({{5{vel_step[5]}}, vel_step});
  end

  // Phase and physics next-state; everything holds between frame ticks.
  always_comb begin
    phase_d    = phase_q;
    bird_y_d   = bird_y_q;
    vel_d      = vel_q;
    dead_d     = dead_q;
    grounded_d = grounded_q;
    if (tick) begin
      if ((phase_q != PH_IDLE) && (state == ST_BEGIN)) begin
        phase_d    = PH_IDLE;
        bird_y_d   = Y_START10;
        vel_d      = '0;
        dead_d     = 1'b0;
        grounded_d = 1'b0;
      end else if (do_fly) begin
        // IDLE already holds Y_START/vel=0, so leaving IDLE applies the
        // first frame of motion on the same tick.
        phase_d = PH_FLY;
        vel_d   = vel_step;
        if (ny >= Y_GND11) begin
          // Ground wins over a simultaneous pipe hit.
          bird_y_d   = Y_GND10;
          dead_d     = 1'b1;
          grounded_d = 1'b1;
          phase_d    = PH_GROUNDED;
        end else if (ny < 0) begin
          bird_y_d = '0;
          dead_d   = 1'b1;
          phase_d  = PH_FALLING;
        end else begin
          bird_y_d = ny[9:0];
          if (hit_pipe) begin
            dead_d  = 1'b1;
            phase_d = PH_FALLING;
          end else if (state == ST_DEAD) begin
            // Controller thinks we are dead without our flag; just drop.
            phase_d = PH_FALLING;
          end
        end
      end else if (phase_q == PH_FALLING) begin
        vel_d = vel_step;
        if (ny >= Y_GND11) begin
          bird_y_d   = Y_GND10;
          grounded_d = 1'b1;
          phase_d    = PH_GROUNDED;
        end else if (ny < 0) begin
          bird_y_d = '0;
        end else begin
          bird_y_d = ny[9:0];
        end
      end
    end
  end

  // Physics registers.
  always_ff @(posedge CLK or negedge SW) begin
    if (!SW) begin
      phase_q    <= PH_IDLE;
      bird_y_q   <= Y_START10;
      vel_q      <= '0;
      dead_q     <= 1'b0;
      grounded_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      bird_y_q   <= bird_y_d;
      vel_q      <= vel_d;
      dead_q     <= dead_d;
      grounded_q <= grounded_d;
    end
  end

  assign frame_tick = tick;
  assign bird_y     = bird_y_q;
  assign dead       = dead_q;
  assign grounded   = grounded_q;

endmodule

// File: tb/tb_bird_motion.sv
// Directed bench for bird_motion with a 4-cycle frame.
module tb_bird_motion;

  logic       CLK;
  logic       SW;
  logic [2:0] state;
  logic       hit_pipe;
  logic       frame_tick;
  logic [9:0] bird_y;
  logic       dead;
  logic       grounded;

  int total;
  int bad;

  bird_motion #(
    .Y_START  (228),
    .GRAVITY  (1),
    .FLAP_VEL (8),
    .VMAX     (10),
    .FRAME_DIV(4)
  ) dut (
    .CLK       (CLK),
    .SW        (SW),
    .state     (state),
    .hit_pipe  (hit_pipe),
    .frame_tick(frame_tick),
    .bird_y    (bird_y),
    .dead      (dead),
    .grounded  (grounded)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Wait for the next frame tick and return 1 ns after the edge that used it.
  task automatic do_tick();
    int n;
    n = 0;
    @(negedge CLK);
    while (frame_tick !== 1'b1 && n < 8) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 8) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: no frame_tick within 8 cycles");
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    SW = 1'b0;
    state = 3'b100;
    hit_pipe = 1'b0;
    #12;
    total++;
    if (bird_y !== 10'd228 || dead !== 1'b0 || grounded !== 1'b0 || frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: y=%0d dead=%b gnd=%b tick=%b want 228 0 0 0",
               bird_y, dead, grounded, frame_tick);
    end
    @(negedge CLK);
    SW = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      total++;
      if (frame_tick !== ((k % 4) == 3)) begin
        bad++;
        $display("FAIL tick_period: cycle %0d tick=%b want %b", k, frame_tick, (k % 4) == 3);
      end
    end
    for (int f = 0; f < 10; f++) begin
      do_tick();
      total++;
      if (bird_y !== 10'd228 || dead !== 1'b0 || grounded !== 1'b0) begin
        bad++;
        $display("FAIL idle_hold: frame %0d y=%0d dead=%b gnd=%b want 228 0 0",
                 f, bird_y, dead, grounded);
      end
    end
  endtask

  task automatic test_free_fall();
    logic [9:0] exp_y [12] = '{229, 231, 234, 238, 243, 249, 256, 264, 273, 283, 293, 303};
    state = 3'b001;
    for (int f = 0; f < 12; f++) begin
      do_tick();
      total++;
      if (bird_y !== exp_y[f] || dead !== 1'b0) begin
        bad++;
        $display("FAIL free_fall: frame %0d y=%0d dead=%b want %0d 0", f, bird_y, dead, exp_y[f]);
      end
    end
    state = 3'b100;
    do_tick();
    total++;
    if (bird_y !== 10'd228 || dead !== 1'b0) begin
      bad++;
      $display("FAIL restart_from_fly: y=%0d dead=%b want 228 0", bird_y, dead);
    end
  endtask

  task automatic test_flap();
    logic [2:0] st [8]    = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b001};
    logic [9:0] exp_y [8] = '{229, 231, 234, 238, 243, 235, 228, 222};
    for (int f = 0; f < 8; f++) begin
      state = st[f];
      do_tick();
      total++;
      if (bird_y !== exp_y[f]) begin
        bad++;
        $display("FAIL flap: frame %0d y=%0d want %0d", f, bird_y, exp_y[f]);
      end
    end
  endtask

  task automatic test_mid_reset();
    state = 3'b100;
    @(negedge CLK);
    @(negedge CLK);
    SW = 1'b0;
    #1;
    total++;
    if (bird_y !== 10'd228 || dead !== 1'b0 || grounded !== 1'b0 || frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: y=%0d dead=%b gnd=%b tick=%b want 228 0 0 0",
               bird_y, dead, grounded, frame_tick);
    end
    @(negedge CLK);
    SW = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      total++;
      if (frame_tick !== (k == 3)) begin
        bad++;
        $display("FAIL divider_restart: cycle %0d tick=%b want %b", k, frame_tick, k == 3);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_ground();
    state = 3'b001;
    for (int f = 1; f <= 27; f++) begin
      do_tick();
    end
    total++;
    if (bird_y !== 10'd453 || dead !== 1'b0 || grounded !== 1'b0) begin
      bad++;
      $display("FAIL pre_ground: y=%0d dead=%b gnd=%b want 453 0 0", bird_y, dead, grounded);
    end
    hit_pipe = 1'b1;
    do_tick();
    hit_pipe = 1'b0;
    total++;
    if (bird_y !== 10'd456 || dead !== 1'b1 || grounded !== 1'b1) begin
      bad++;
      $display("FAIL ground_hit: y=%0d dead=%b gnd=%b want 456 1 1", bird_y, dead, grounded);
    end
    state = 3'b010;
    for (int f = 0; f < 3; f++) begin
      do_tick();
      total++;
      if (bird_y !== 10'd456 || dead !== 1'b1 || grounded !== 1'b1) begin
        bad++;
        $display("FAIL grounded_hold: frame %0d y=%0d dead=%b gnd=%b want 456 1 1",
                 f, bird_y, dead, grounded);
      end
    end
  endtask

  task automatic test_restart();
    state = 3'b100;
    do_tick();
    total++;
    if (bird_y !== 10'd228 || dead !== 1'b0 || grounded !== 1'b0) begin
      bad++;
      $display("FAIL restart: y=%0d dead=%b gnd=%b want 228 0 0", bird_y, dead, grounded);
    end
  endtask

  task automatic test_pipe_hit();
    logic [9:0] exp_y [8] = '{268, 262, 257, 253, 250, 248, 247, 247};
    state = 3'b001;
    for (int f = 1; f <= 10; f++) begin
      do_tick();
    end
    total++;
    if (bird_y !== 10'd283) begin
      bad++;
      $display("FAIL pipe_setup: y=%0d want 283", bird_y);
    end
    state = 3'b010;
    hit_pipe = 1'b1;
    do_tick();
    hit_pipe = 1'b0;
    total++;
    if (bird_y !== 10'd275 || dead !== 1'b1 || grounded !== 1'b0) begin
      bad++;
      $display("FAIL pipe_hit: y=%0d dead=%b gnd=%b want 275 1 0", bird_y, dead, grounded);
    end
    for (int f = 1; f <= 34; f++) begin
      do_tick();
      if (f <= 8) begin
        total++;
        if (bird_y !== exp_y[f-1] || dead !== 1'b1) begin
          bad++;
          $display("FAIL pipe_decel: frame %0d y=%0d dead=%b want %0d 1",
                   f, bird_y, dead, exp_y[f-1]);
        end
      end
      if (f == 33) begin
        total++;
        if (bird_y !== 10'd452 || grounded !== 1'b0) begin
          bad++;
          $display("FAIL pipe_fall: y=%0d gnd=%b want 452 0", bird_y, grounded);
        end
      end
    end
    total++;
    if (bird_y !== 10'd456 || dead !== 1'b1 || grounded !== 1'b1) begin
      bad++;
      $display("FAIL pipe_grounded: y=%0d dead=%b gnd=%b want 456 1 1", bird_y, dead, grounded);
    end
    state = 3'b100;
    do_tick();
  endtask

  task automatic test_ceiling();
    state = 3'b010;
    for (int f = 1; f <= 28; f++) begin
      do_tick();
    end
    total++;
    if (bird_y !== 10'd4 || dead !== 1'b0) begin
      bad++;
      $display("FAIL pre_ceiling: y=%0d dead=%b want 4 0", bird_y, dead);
    end
    do_tick();
    total++;
    if (bird_y !== 10'd0 || dead !== 1'b1 || grounded !== 1'b0) begin
      bad++;
      $display("FAIL ceiling_hit: y=%0d dead=%b gnd=%b want 0 1 0", bird_y, dead, grounded);
    end
    do_tick();
    total++;
    if (bird_y !== 10'd0 || dead !== 1'b1 || grounded !== 1'b0) begin
      bad++;
      $display("FAIL ceiling_clamp: y=%0d dead=%b gnd=%b want 0 1 0", bird_y, dead, grounded);
    end
    state = 3'b100;
    do_tick();
    total++;
    if (bird_y !== 10'd228 || dead !== 1'b0) begin
      bad++;
      $display("FAIL restart_from_falling: y=%0d dead=%b want 228 0", bird_y, dead);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_free_fall();
    test_flap();
    test_mid_reset();
    test_ground();
    test_restart();
    test_pipe_hit();
    test_ceiling();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bird_motion.md
Name: bird_motion

Overview:
- Per-frame vertical physics engine for the bird. Sits directly downstream of the game controller: consumes its 3-bit `state`, and produces `bird_y` for the VGA renderer.
- Generates the frame tick that drives the controller's `VGAfeedback` input, and returns the `dead` flag the controller samples.
- Owns gravity, flap impulse, ground/ceiling/pipe collision and the post-death fall-to-ground animation.

Parameters:
- SCREEN_H, 480, visible screen height in pixels.
- BIRD_H, 24, bird sprite height in pixels.
- Y_START, 228, bird top-edge y in the idle (begin) state.
- GRAVITY, 1, velocity increment per frame (px/frame).
- FLAP_VEL, 8, upward velocity magnitude applied on a flap.
- VMAX, 10, terminal downward velocity (px/frame).
- FRAME_DIV, 833333, CLK cycles per physics frame (50 MHz / 60 Hz); the bench uses 4.

Ports:
- CLK  in  1  system clock.
- SW  in  1  asynchronous active-low reset (0 = reset).
- state  in  3  controller state: 3'b100 begin, 3'b001 down, 3'b010 up, 3'b011 dead.
- hit_pipe  in  1  level from the pipe/collision logic: bird overlaps a pipe.
- frame_tick  out  1  one-CLK pulse per frame; wired to the controller's VGAfeedback.
- bird_y  out  10  bird top-edge y in pixels, unsigned.
- dead  out  1  sticky collision flag; wired to the controller's dead input.
- grounded  out  1  high once the dead bird has reached the ground.

Behaviour:
- Reset (SW=0, async), all outputs and internal state forced to these values:
  - frame counter=0, frame_tick=0
  - bird_y=Y_START, vel=0
  - dead=0, grounded=0
  - phase=IDLE
- Frame divider:
  - Counter runs 0..FRAME_DIV-1 and wraps.
  - frame_tick=1 for exactly the cycle the counter equals FRAME_DIV-1.
  - Period is exactly FRAME_DIV cycles; it runs in every phase.
- Update timing: all physics updates occur only on cycles with frame_tick=1; otherwise the registers hold.
- vel is signed 6-bit, negative meaning upward. Next position is computed as signed 11-bit: ny = bird_y + vel.
- Internal phases, evaluated on frame_tick:
  - IDLE:
    - bird_y=Y_START, vel=0, dead=0, grounded=0.
    - When state==down or state==up, go to FLY in the same tick.
  - FLY: velocity update.
    - If state==up: vel=-FLAP_VEL.
    - Otherwise: vel=min(vel+GRAVITY, VMAX).
  - FLY: position update. ny is computed with the new vel.
    - If ny<0: bird_y=0, dead=1.
    - If ny>=SCREEN_H-BIRD_H: bird_y=SCREEN_H-BIRD_H, dead=1, grounded=1, go to GROUNDED.
    - Otherwise: bird_y=ny.
  - FLY: pipe collision. If hit_pipe=1 on the tick, dead=1 and go to FALLING; the position update still applies on that tick.
  - FLY: ceiling hit (ny<0) also goes to FALLING.
  - FALLING:
    - Flap ignored; vel=min(vel+GRAVITY, VMAX) with no floor at 0, so an upward vel decays.
    - bird_y clamps to 0 at the top.
    - On reaching SCREEN_H-BIRD_H: clamp, grounded=1, go to GROUNDED.
  - GROUNDED: bird_y, vel, dead and grounded held.
- Return to IDLE: from FLY, FALLING or GROUNDED, state==begin (controller reset) on a tick goes to IDLE with all IDLE values.
- state==dead while in FLY with dead=0 (should not occur): go to FALLING; dead is not set by this block.
- Latency:
  - dead changes on the same edge that frame_tick is high. The controller, sampling on that same edge, sees the old value, so death registers one frame later. This is accepted.
- Simultaneous events, all resolved on the same tick:
  - hit_pipe together with a ground hit: GROUNDED wins.
  - A flap together with a ceiling clamp: dead and FALLING.
- hit_pipe is sampled only on frame_tick; between ticks it is don't-care.
- Reset asserted mid-frame: immediate return to reset values; the divider restarts at 0.

Decomposition:
- Shared package (game_pkg):
  - state encodings ST_BEGIN=3'b100, ST_DOWN=3'b001, ST_UP=3'b010, ST_DEAD=3'b011, shared with the controller.
  - SCREEN_H and BIRD_H.
- Sub-module frame_divider: parameter FRAME_DIV; ports CLK, SW, tick. It is reusable by the pipe scroller.
- Phase encoding is local to bird_motion.

Test Plan:
- Reset/idle: SW=0 then 1, state=100, FRAME_DIV=4 -> frame_tick every 4th cycle; bird_y=228, dead=0, grounded=0 for 10 frames.
- Free fall: state=001 from y=228 -> bird_y sequence 229,231,234,238,243,… with vel saturating at 10, after which y grows by 10 per frame.
- Flap: after 5 down frames (y=243, vel=5), one tick with state=010 then 001 -> y=235, then 235-7=228, 228-6=222.
- Ground hit: fall until ny>=456 -> bird_y=456, dead=1, grounded=1 on the same tick; the values hold for following frames.
- Pipe hit: hit_pipe=1 on a tick at y=300, vel=-8 -> dead=1 and y=292; bird decelerates, falls, grounds at 456; state=010 is ignored.
- Restart and async reset: in GROUNDED, state=100 on a tick -> y=228, dead=0, grounded=0. Separately, SW pulsed low mid-frame -> outputs reset immediately and the divider restarts.
